// File: rtl/eth_cfg_pkg.sv
// Shared types and encodings for the Ethernet MAC configuration sequencer.
// BRESP values follow AXI; error codes are what the router control logic sees.
package eth_cfg_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_RESP,
      S_DONE,
      S_ERROR
   } state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_SLV  = 2'b01;
   localparam logic [1:0] ERR_DEC  = 2'b10;
   localparam logic [1:0] ERR_TMO  = 2'b11;

   function automatic logic resp_ok(input logic [1:0] r);
      return (r == RESP_OKAY) || (r == RESP_EXOKAY);
   endfunction

   function automatic logic [1:0] resp_code(input logic [1:0] r);
      return (r == RESP_DECERR) ? ERR_DEC : ERR_SLV;
   endfunction

endpackage

// File: rtl/axil_single_write.sv
// One AXI-Lite write (AW + W + B) with independent AW/W handshakes.
// Shared with the read-back checker; abort drops every valid/ready at once.
module axil_single_write (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic [31:0] addr,
   input  logic [31:0] data,
   output logic        issued,
   output logic [1:0]  resp,
   output logic        resp_valid,
   output logic [31:0] aw_addr,
   output logic        aw_valid,
   input  logic        aw_ready,
   output logic [31:0] w_data,
   output logic [3:0]  w_strb,
   output logic        w_valid,
   input  logic        w_ready,
   input  logic [1:0]  b_resp,
   input  logic        b_valid,
   output logic        b_ready
);

   logic busy;
   logic b_phase;
   logic aw_ok;
   logic w_ok;

   assign aw_ok      = ~aw_valid | aw_ready;
   assign w_ok       = ~w_valid | w_ready;
   assign issued     = busy & ~b_phase & aw_ok & w_ok;
   assign b_ready    = b_phase;
   assign resp_valid = b_phase & b_valid;
   assign resp       = b_resp;
   assign w_strb     = 4'hF;

   always_ff @(posedge clk) begin
      if (rst || abort) begin
         aw_valid <= 1'b0;
         w_valid  <= 1'b0;
         busy     <= 1'b0;
         b_phase  <= 1'b0;
      end else if (start) begin
         aw_valid <= 1'b1;
         w_valid  <= 1'b1;
         busy     <= 1'b1;
         b_phase  <= 1'b0;
      end else begin
         if (aw_ready) aw_valid <= 1'b0;
         if (w_ready) w_valid <= 1'b0;
         if (issued) b_phase <= 1'b1;
         if (resp_valid) begin
            busy    <= 1'b0;
            b_phase <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         aw_addr <= '0;
         w_data  <= '0;
      end else if (start) begin
         aw_addr <= addr;
         w_data  <= data;
      end
   end

endmodule

// File: rtl/eth_cfg_sequencer.sv
// Issues a captured table of MAC register writes over AXI-Lite in index order,
// with BRESP retry, a per-write response timeout and done/error reporting.
module eth_cfg_sequencer #(
   parameter logic [31:0] BASE_ADDR = 32'h40C0_0000,
   parameter int          N_WORDS   = 4,
   parameter int          MAX_RETRY = 2,
   parameter int          TIMEOUT   = 1024,
   parameter int          IDX_W     = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [12*N_WORDS-1:0] cfg_offset,
   input  logic [32*N_WORDS-1:0] cfg_data,
   output logic                  cfg_done,
   output logic                  cfg_error,
   output logic [IDX_W-1:0]      cfg_err_idx,
   output logic [1:0]            cfg_err_code,
   output logic [31:0]           M_AXI_AWADDR,
   output logic                  M_AXI_AWVALID,
   input  logic                  M_AXI_AWREADY,
   output logic [31:0]           M_AXI_WDATA,
   output logic [3:0]            M_AXI_WSTRB,
   output logic                  M_AXI_WVALID,
   input  logic                  M_AXI_WREADY,
   input  logic [1:0]            M_AXI_BRESP,
   input  logic                  M_AXI_BVALID,
   output logic                  M_AXI_BREADY
);
   import eth_cfg_pkg::*;

   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(N_WORDS - 1);
   localparam logic [RW-1:0]    RMAX = RW'(MAX_RETRY);
   localparam logic [TW-1:0]    TLIM = TW'(TIMEOUT - 1);

   state_t            state;
   state_t            nxt;
   logic [11:0]       off_q [N_WORDS];
   logic [31:0]       dat_q [N_WORDS];
   logic [IDX_W-1:0]  idx;
   logic [IDX_W-1:0]  nxt_idx;
   logic [RW-1:0]     retry;
   logic [TW-1:0]     tcnt;
   logic              start;
   logic              issued;
   logic              resp_valid;
   logic [1:0]        resp;
   logic              tmo;
   logic              ok;
   logic              accept;
   logic              active;
   logic [11:0]       sel_off;
   logic [31:0]       sel_dat;

   assign accept    = (state == S_IDLE) && cfg_valid;
   assign active    = (state == S_ISSUE) || (state == S_RESP);
   assign ok        = resp_ok(resp);
   assign tmo       = active && (tcnt == TLIM) && !resp_valid;
   assign cfg_ready = (state == S_IDLE);
   assign cfg_done  = (state == S_DONE);
   assign cfg_error = (state == S_ERROR);

   always_comb begin
      nxt     = state;
      start   = 1'b0;
      nxt_idx = idx;
      case (state)
         S_IDLE: begin
            if (cfg_valid) begin
               nxt     = S_ISSUE;
               start   = 1'b1;
               nxt_idx = '0;
            end
         end
         S_ISSUE: begin
            if (tmo) nxt = S_ERROR;
            else if (issued) nxt = S_RESP;
         end
         S_RESP: begin
            if (tmo) begin
               nxt = S_ERROR;
            end else if (resp_valid) begin
               if (ok && idx == LAST) begin
                  nxt = S_DONE;
               end else if (ok) begin
                  nxt     = S_ISSUE;
                  start   = 1'b1;
                  nxt_idx = idx + 1'b1;
               end else if (retry < RMAX) begin
                  nxt   = S_ISSUE;
                  start = 1'b1;
               end else begin
                  nxt = S_ERROR;
               end
            end
         end
         default: nxt = S_IDLE;
      endcase
   end

   // The first write launches in the accept cycle, before the table is stored.
   always_comb begin
      sel_off = off_q[nxt_idx];
      sel_dat = dat_q[nxt_idx];
      if (state == S_IDLE) begin
         sel_off = cfg_offset[11:0];
         sel_dat = cfg_data[31:0];
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state        <= S_IDLE;
         idx          <= '0;
         retry        <= '0;
         tcnt         <= '0;
         cfg_err_idx  <= '0;
         cfg_err_code <= ERR_NONE;
      end else begin
         state <= nxt;
         if (start) tcnt <= '0;
         else if (active && tcnt != TLIM) tcnt <= tcnt + 1'b1;
         if (accept) begin
            idx          <= '0;
            retry        <= '0;
            cfg_err_idx  <= '0;
            cfg_err_code <= ERR_NONE;
         end
         if (state == S_RESP && resp_valid) begin
            if (ok) begin
               idx   <= nxt_idx;
               retry <= '0;
            end else if (retry < RMAX) begin
               retry <= retry + 1'b1;
            end else begin
               cfg_err_idx  <= idx;
               cfg_err_code <= resp_code(resp);
            end
         end
         if (tmo) begin
            cfg_err_idx  <= idx;
            cfg_err_code <= ERR_TMO;
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (accept) begin
         for (int i = 0; i < N_WORDS; i++) begin
            off_q[i] <= cfg_offset[12*i +: 12];
            dat_q[i] <= cfg_data[32*i +: 32];
         end
      end
   end

   axil_single_write u_wr (
      .clk        (aclk),
      .rst        (areset),
      .start      (start),
      .abort      (tmo),
      .addr       (BASE_ADDR + {20'd0, sel_off}),
      .data       (sel_dat),
      .issued     (issued),
      .resp       (resp),
      .resp_valid (resp_valid),
      .aw_addr    (M_AXI_AWADDR),
      .aw_valid   (M_AXI_AWVALID),
      .aw_ready   (M_AXI_AWREADY),
      .w_data     (M_AXI_WDATA),
      .w_strb     (M_AXI_WSTRB),
      .w_valid    (M_AXI_WVALID),
      .w_ready    (M_AXI_WREADY),
      .b_resp     (M_AXI_BRESP),
      .b_valid    (M_AXI_BVALID),
      .b_ready    (M_AXI_BREADY)
   );

endmodule

// File: tb/tb_eth_cfg_sequencer.sv
// Directed bench for eth_cfg_sequencer with a scripted AXI-Lite slave.
// N_WORDS=4, MAX_RETRY=2, TIMEOUT=16.
module tb_eth_cfg_sequencer;

   logic          aclk;
   logic          areset;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [47:0]   cfg_offset;
   logic [127:0]  cfg_data;
   logic          cfg_done;
   logic          cfg_error;
   logic [1:0]    cfg_err_idx;
   logic [1:0]    cfg_err_code;
   logic [31:0]   awaddr;
   logic          awvalid;
   logic          awready;
   logic [31:0]   wdata;
   logic [3:0]    wstrb;
   logic          wvalid;
   logic          wready;
   logic [1:0]    bresp;
   logic          bvalid;
   logic          bready;

   int npass = 0;
   int nfail = 0;
   int nchk  = 0;
   int c;

   int          aw_cnt, w_cnt, n_aw, n_w, n_b;
   logic        got_aw, got_w;
   logic [31:0] log_addr [32];
   logic [31:0] log_data [32];
   int          awl [32];
   int          wl [32];
   logic [1:0]  bscript [32];
   bit          no_b;
   bit          mon_en;
   logic        p_awv, p_awr, p_wv, p_wr;
   logic [31:0] p_aw, p_wd;
   logic [31:0] td [4];
   logic [31:0] ta [6];

   eth_cfg_sequencer #(
      .N_WORDS   (4),
      .MAX_RETRY (2),
      .TIMEOUT   (16)
   ) dut (
      .aclk          (aclk),
      .areset        (areset),
      .cfg_valid     (cfg_valid),
      .cfg_ready     (cfg_ready),
      .cfg_offset    (cfg_offset),
      .cfg_data      (cfg_data),
      .cfg_done      (cfg_done),
      .cfg_error     (cfg_error),
      .cfg_err_idx   (cfg_err_idx),
      .cfg_err_code  (cfg_err_code),
      .M_AXI_AWADDR  (awaddr),
      .M_AXI_AWVALID (awvalid),
      .M_AXI_AWREADY (awready),
      .M_AXI_WDATA   (wdata),
      .M_AXI_WSTRB   (wstrb),
      .M_AXI_WVALID  (wvalid),
      .M_AXI_WREADY  (wready),
      .M_AXI_BRESP   (bresp),
      .M_AXI_BVALID  (bvalid),
      .M_AXI_BREADY  (bready)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   // Slave: ready after a scripted wait; BVALID one cycle after both handshakes.
   assign awready = awvalid && (aw_cnt >= awl[n_aw[4:0]]);
   assign wready  = wvalid && (w_cnt >= wl[n_w[4:0]]);

   always @(posedge aclk) begin
      if (areset) begin
         aw_cnt <= 0; w_cnt <= 0;
         n_aw <= 0; n_w <= 0; n_b <= 0;
         got_aw <= 1'b0; got_w <= 1'b0;
         bvalid <= 1'b0; bresp <= 2'b00;
      end else begin
         if (awvalid) begin
            if (awready) begin
               aw_cnt <= 0;
               got_aw <= 1'b1;
               log_addr[n_aw[4:0]] <= awaddr;
               n_aw <= n_aw + 1;
            end else aw_cnt <= aw_cnt + 1;
         end
         if (wvalid) begin
            if (wready) begin
               w_cnt <= 0;
               got_w <= 1'b1;
               log_data[n_w[4:0]] <= wdata;
               n_w <= n_w + 1;
            end else w_cnt <= w_cnt + 1;
         end
         if (bvalid && bready) begin
            bvalid <= 1'b0;
            got_aw <= 1'b0;
            got_w  <= 1'b0;
            n_b    <= n_b + 1;
         end else if (got_aw && got_w && !bvalid && !no_b) begin
            bvalid <= 1'b1;
            bresp  <= bscript[n_b[4:0]];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // A pending valid must hold with stable payload until its ready.
   always @(negedge aclk) begin
      if (mon_en) begin
         if (p_awv && !p_awr) begin
            chk("aw_hold", 32'(awvalid), 1);
            chk("aw_stable", awaddr, p_aw);
         end
         if (p_wv && !p_wr) begin
            chk("w_hold", 32'(wvalid), 1);
            chk("w_stable", wdata, p_wd);
         end
      end
      p_awv = awvalid; p_awr = awready; p_aw = awaddr;
      p_wv = wvalid; p_wr = wready; p_wd = wdata;
   end

   task automatic tick;
      @(posedge aclk);
      #1;
   endtask

   task automatic do_reset;
      areset = 1'b1;
      tick;
      tick;
      areset = 1'b0;
   endtask

   task automatic accept;
      cfg_valid = 1'b1;
      tick;
      cfg_valid = 1'b0;
   endtask

   task automatic wait_end(output int cyc);
      cyc = 1;
      while (!(cfg_done || cfg_error) && cyc < 200) begin
         tick;
         cyc++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      areset = 1'b1;
      cfg_valid = 1'b0;
      no_b = 1'b0;
      mon_en = 1'b0;
      for (int i = 0; i < 32; i++) begin
         awl[i] = 0; wl[i] = 0; bscript[i] = 2'b00;
      end
      cfg_offset = {12'h70C, 12'h708, 12'h704, 12'h700};
      cfg_data = {32'h0BADF00D, 32'hDEADBEEF, 32'h00005544, 32'h33221100};
      td[0] = 32'h33221100; td[1] = 32'h00005544;
      td[2] = 32'hDEADBEEF; td[3] = 32'h0BADF00D;
      tick;
      tick;

      // reset state
      chk("rst_ready", 32'(cfg_ready), 1);
      chk("rst_done", 32'(cfg_done), 0);
      chk("rst_error", 32'(cfg_error), 0);
      chk("rst_err_idx", 32'(cfg_err_idx), 0);
      chk("rst_err_code", 32'(cfg_err_code), 0);
      chk("rst_awvalid", 32'(awvalid), 0);
      chk("rst_wvalid", 32'(wvalid), 0);
      chk("rst_bready", 32'(bready), 0);
      chk("rst_awaddr", awaddr, 0);
      chk("rst_wdata", wdata, 0);
      areset = 1'b0;
      tick;

      // zero-wait slave, four writes
      accept;
      chk("t1_ready_drop", 32'(cfg_ready), 0);
      chk("t1_awvalid", 32'(awvalid), 1);
      chk("t1_wvalid", 32'(wvalid), 1);
      chk("t1_awaddr0", awaddr, 32'h40C00700);
      chk("t1_wdata0", wdata, 32'h33221100);
      chk("t1_wstrb", 32'(wstrb), 32'hF);
      wait_end(c);
      chk("t1_cycles", c, 13);
      chk("t1_done", 32'(cfg_done), 1);
      chk("t1_nwrites", n_aw, 4);
      for (int i = 0; i < 4; i++) begin
         chk("t1_addr", log_addr[i], 32'h40C00700 + 32'(4 * i));
         chk("t1_data", log_data[i], td[i]);
      end
      tick;
      chk("t1_done_pulse", 32'(cfg_done), 0);
      chk("t1_ready_back", 32'(cfg_ready), 1);
      chk("t1_err_code", 32'(cfg_err_code), 0);

      // independent AW/W handshakes
      do_reset;
      awl[0] = 0; wl[0] = 3;
      awl[1] = 3; wl[1] = 0;
      mon_en = 1'b1;
      accept;
      tick;
      chk("t2_aw_first", 32'(awvalid), 0);
      chk("t2_w_wait", 32'(wvalid), 1);
      tick;
      tick;
      chk("t2_w_still", 32'(wvalid), 1);
      chk("t2_wdata_hold", wdata, 32'h33221100);
      tick;
      chk("t2_w_taken", 32'(wvalid), 0);
      chk("t2_bready", 32'(bready), 1);
      tick;
      tick;
      tick;
      chk("t2_aw_wait", 32'(awvalid), 1);
      chk("t2_w_first", 32'(wvalid), 0);
      chk("t2_awaddr1", awaddr, 32'h40C00704);
      wait_end(c);
      chk("t2_done", 32'(cfg_done), 1);
      chk("t2_nwrites", n_aw, 4);
      for (int i = 0; i < 4; i++) begin
         chk("t2_addr", log_addr[i], 32'h40C00700 + 32'(4 * i));
         chk("t2_data", log_data[i], td[i]);
      end
      mon_en = 1'b0;
      awl[1] = 0; wl[0] = 0;
      tick;

      // SLVERR twice on entry 1, then OKAY
      do_reset;
      bscript[1] = 2'b10; bscript[2] = 2'b10;
      ta[0] = 32'h40C00700; ta[1] = 32'h40C00704; ta[2] = 32'h40C00704;
      ta[3] = 32'h40C00704; ta[4] = 32'h40C00708; ta[5] = 32'h40C0070C;
      accept;
      wait_end(c);
      chk("t3_cycles", c, 19);
      chk("t3_done", 32'(cfg_done), 1);
      chk("t3_error", 32'(cfg_error), 0);
      chk("t3_nwrites", n_aw, 6);
      for (int i = 0; i < 6; i++) chk("t3_addr", log_addr[i], ta[i]);
      chk("t3_data_retry", log_data[3], 32'h00005544);
      bscript[1] = 2'b00; bscript[2] = 2'b00;
      tick;

      // DECERR three times on entry 2
      do_reset;
      bscript[2] = 2'b11; bscript[3] = 2'b11; bscript[4] = 2'b11;
      accept;
      wait_end(c);
      chk("t4_cycles", c, 16);
      chk("t4_error", 32'(cfg_error), 1);
      chk("t4_done", 32'(cfg_done), 0);
      chk("t4_err_idx", 32'(cfg_err_idx), 2);
      chk("t4_err_code", 32'(cfg_err_code), 2);
      chk("t4_nwrites", n_aw, 5);
      chk("t4_last_addr", log_addr[4], 32'h40C00708);
      chk("t4_awvalid", 32'(awvalid), 0);
      tick;
      chk("t4_err_pulse", 32'(cfg_error), 0);
      chk("t4_ready_back", 32'(cfg_ready), 1);
      chk("t4_code_held", 32'(cfg_err_code), 2);
      chk("t4_idx_held", 32'(cfg_err_idx), 2);
      for (int i = 0; i < 32; i++) bscript[i] = 2'b00;

      // slave never responds: timeout, no retry
      no_b = 1'b1;
      accept;
      chk("t5_code_clr", 32'(cfg_err_code), 0);
      chk("t5_idx_clr", 32'(cfg_err_idx), 0);
      wait_end(c);
      chk("t5_cycles", c, 17);
      chk("t5_error", 32'(cfg_error), 1);
      chk("t5_err_code", 32'(cfg_err_code), 3);
      chk("t5_err_idx", 32'(cfg_err_idx), 0);
      chk("t5_awvalid", 32'(awvalid), 0);
      chk("t5_wvalid", 32'(wvalid), 0);
      chk("t5_bready", 32'(bready), 0);
      chk("t5_nwrites", n_aw, 6);
      tick;
      chk("t5_ready_back", 32'(cfg_ready), 1);
      no_b = 1'b0;

      // reset while entry 1 waits for its response
      do_reset;
      accept;
      tick;
      tick;
      tick;
      tick;
      chk("t6_in_resp", 32'(bready), 1);
      chk("t6_entry1", awaddr, 32'h40C00704);
      areset = 1'b1;
      tick;
      chk("t6_ready", 32'(cfg_ready), 1);
      chk("t6_no_done", 32'(cfg_done), 0);
      chk("t6_no_error", 32'(cfg_error), 0);
      chk("t6_awvalid", 32'(awvalid), 0);
      chk("t6_bready", 32'(bready), 0);
      areset = 1'b0;
      tick;
      chk("t6_idle_no_pulse", 32'(cfg_done | cfg_error), 0);
      cfg_offset = {12'h10C, 12'h108, 12'h104, 12'h100};
      cfg_data = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};
      accept;
      wait_end(c);
      chk("t6_cycles", c, 13);
      chk("t6_done", 32'(cfg_done), 1);
      chk("t6_nwrites", n_aw, 4);
      chk("t6_addr0", log_addr[0], 32'h40C00100);
      chk("t6_addr3", log_addr[3], 32'h40C0010C);
      chk("t6_data0", log_data[0], 32'hA0A0A0A0);
      chk("t6_data3", log_data[3], 32'hA3A3A3A3);
      tick;

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
